// File: rtl/amount_display.sv
// Sequential double-dabble of the dispenser volume onto four 7-segment digits.
// Optional: AMOUNT_DISPLAY_LEADING_ZERO_BLANKING_EN blanks leading zero digits.
module amount_display #(
  parameter int AMOUNT_WIDTH = 32,
  parameter bit SEGMENTS_ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AMOUNT_WIDTH-1:0] amount_in_ml,
  output logic [6:0]              hex0,
  output logic [6:0]              hex1,
  output logic [6:0]              hex2,
  output logic [6:0]              hex3,
  output logic                    busy
);

  typedef enum logic [1:0] {
    LOAD,
    CONVERT,
    UPDATE,
    IDLE
  } state_t;

  localparam logic [AMOUNT_WIDTH-1:0] MAX_VAL = AMOUNT_WIDTH'(9999);
  localparam logic [6:0] POL = SEGMENTS_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] DASH = 7'h40;

  state_t state, state_n;

  logic [AMOUNT_WIDTH-1:0] snapshot;
  logic [AMOUNT_WIDTH-1:0] last_value;
  logic [13:0]             shreg;
  logic [15:0]             bcd;
  logic [15:0]             bcd_adj;
  logic [3:0]              cnt;
  logic                    ovf;
  logic [3:0]              blank;
  logic [6:0]              pat [4];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:    state_n = (amount_in_ml > MAX_VAL) ? UPDATE : CONVERT;
      CONVERT: if (cnt == 4'd13) state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      IDLE:    if (amount_in_ml != last_value) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4+:4] >= 4'd5)
        bcd_adj[i*4+:4] = bcd[i*4+:4] + 4'd3;
    end
  end

  // Units digit is never blanked, so only the upper three get a flag.
  always_comb begin
    blank = 4'b0000;
`ifdef AMOUNT_DISPLAY_LEADING_ZERO_BLANKING_EN
    blank[3] = (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      if (ovf)
        pat[i] = DASH ^ POL;
      else if (blank[i])
        pat[i] = POL;
      else
        pat[i] = seg7(bcd[i*4+:4]) ^ POL;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      busy       <= 1'b0;
      snapshot   <= '0;
      last_value <= '0;
      shreg      <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      hex0       <= POL;
      hex1       <= POL;
      hex2       <= POL;
      hex3       <= POL;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      unique case (state)
        LOAD: begin
          snapshot <= amount_in_ml;
          ovf      <= (amount_in_ml > MAX_VAL);
          shreg    <= amount_in_ml[13:0];
          bcd      <= '0;
          cnt      <= '0;
        end
        CONVERT: begin
          {bcd, shreg} <= {bcd_adj, shreg} << 1;
          cnt          <= cnt + 4'd1;
        end
        UPDATE: begin
          hex0       <= pat[0];
          hex1       <= pat[1];
          hex2       <= pat[2];
          hex3       <= pat[3];
          last_value <= snapshot;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_amount_display.sv
// Bench for amount_display: random amounts against a decimal digit model.
// Honors AMOUNT_DISPLAY_LEADING_ZERO_BLANKING_EN for expected blanking.
module tb_amount_display;

  logic        clock;
  logic        reset;
  logic [31:0] amount_in_ml;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        busy;

  int vectors;
  int miscompares;
  logic [31:0] shown_val;

  logic [6:0] seg_tab [10];
  int         pow10 [4];

  amount_display dut (
    .clock        (clock),
    .reset        (reset),
    .amount_in_ml (amount_in_ml),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic logic [6:0] exp_hex(input logic [31:0] v, input int i);
    logic [6:0] s;
    int d;
    if (v > 32'd9999) begin
      s = 7'h40;
    end else begin
      d = (int'(v) / pow10[i]) % 10;
      s = seg_tab[d];
`ifdef AMOUNT_DISPLAY_LEADING_ZERO_BLANKING_EN
      if (i > 0 && int'(v) < pow10[i]) s = 7'h00;
`endif
    end
    return s ^ 7'h7F;
  endfunction

  function automatic logic [6:0] hex_of(input int i);
    logic [6:0] h;
    case (i)
      0: h = hex0;
      1: h = hex1;
      2: h = hex2;
      default: h = hex3;
    endcase
    return h;
  endfunction

  task automatic wait_conv(input int exp_cycles, input logic [31:0] v,
                           input string name);
    int cycles;
    cycles = 0;
    @(negedge clock);
    while (busy && cycles < 100) begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (hex_of(i) !== exp_hex(shown_val, i)) begin
          miscompares++;
          $display("FAIL %s hold hex%0d got %h want %h", name, i,
                   hex_of(i), exp_hex(shown_val, i));
        end
      end
      cycles++;
      @(negedge clock);
    end
    if (exp_cycles >= 0) begin
      vectors++;
      if (cycles !== exp_cycles) begin
        miscompares++;
        $display("FAIL %s busy_cycles got %0d want %0d", name, cycles,
                 exp_cycles);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hex_of(i) !== exp_hex(v, i)) begin
        miscompares++;
        $display("FAIL %s value %0d hex%0d got %h want %h", name, v, i,
                 hex_of(i), exp_hex(v, i));
      end
    end
    shown_val = v;
  endtask

  task automatic apply(input logic [31:0] v, input string name);
    @(negedge clock);
    amount_in_ml = v;
    wait_conv((v > 32'd9999) ? 2 : 16, v, name);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    amount_in_ml = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hex_of(i) !== 7'h7F) begin
        miscompares++;
        $display("FAIL reset hex%0d got %h want 7f", i, hex_of(i));
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset busy got %b want 0", busy);
    end
    reset = 1'b0;
    repeat (15) @(negedge clock);
    vectors++;
    if (hex0 !== 7'h7F) begin
      miscompares++;
      $display("FAIL reset early_update hex0 got %h want 7f", hex0);
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hex_of(i) !== exp_hex(32'd0, i)) begin
        miscompares++;
        $display("FAIL reset first_conv hex%0d got %h want %h", i,
                 hex_of(i), exp_hex(32'd0, i));
      end
    end
    shown_val = 32'd0;
  endtask

  task automatic test_fixed;
    apply(32'd42, "fixed42");
    apply(32'd9999, "fixed9999");
    apply(32'd1234, "fixed1234");
    apply(32'd7, "fixed7");
    apply(32'd0, "fixed0");
  endtask

  task automatic test_random;
    logic [31:0] v;
    for (int k = 0; k < 10; k++) begin
      v = 32'($urandom_range(0, 9999));
      if (v == shown_val) v = (v + 1) % 10000;
      apply(v, "random");
    end
  endtask

  task automatic test_overflow;
    apply(32'd10000, "ovf10000");
    apply(32'hFFFF_FFFF, "ovf_max");
    apply(32'h0004_002A, "ovf_alias");
    apply(32'd5, "ovf_recover");
    apply(32'($urandom_range(10000, 32'h7FFF_FFFF)), "ovf_random");
  endtask

  task automatic test_mid_change;
    apply(32'd3, "mid_pre");
    @(negedge clock);
    amount_in_ml = 32'd42;
    repeat (3) @(negedge clock);
    amount_in_ml = 32'd7;
    repeat (3) @(negedge clock);
    amount_in_ml = 32'd815;
    wait_conv(-1, 32'd42, "mid_first");
    wait_conv(16, 32'd815, "mid_second");
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    v = 32'($urandom_range(1000, 9999));
    @(negedge clock);
    amount_in_ml = v;
    repeat (5) @(negedge clock);
    #5 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hex_of(i) !== 7'h7F) begin
        miscompares++;
        $display("FAIL reset_mid async hex%0d got %h want 7f", i, hex_of(i));
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid busy got %b want 0", busy);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (17) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (hex_of(i) !== exp_hex(v, i)) begin
        miscompares++;
        $display("FAIL reset_mid reconv hex%0d got %h want %h", i,
                 hex_of(i), exp_hex(v, i));
      end
    end
    shown_val = v;
    apply(32'd58, "after_reset_mid");
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    pow10 = '{1, 10, 100, 1000};
    vectors = 0;
    miscompares = 0;
    shown_val = '0;
    reset = 1'b1;
    amount_in_ml = '0;
    test_reset();
    test_fixed();
    test_random();
    test_overflow();
    test_mid_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
